// File: rtl/simulador_planta_esteira_if.sv
// Actuator/sensor bundle between the bottling controller and the plant.
// master = controller side, slave = plant emulator side.
interface simulador_planta_esteira_if;
  logic       TICK;
  logic       LED_MOTOR;
  logic       VALVULA_ENCHIMENTO;
  logic       ATUADOR_VEDACAO;
  logic       SENSOR_POS_ENCHIMENTO;
  logic       SENSOR_POS_CQ;
  logic       SENSOR_POS_LACRE;
  logic       SENSOR_GARRAFA_CHEIA;
  logic       GARRAFA_PRESENTE;
  logic [7:0] NIVEL;
  logic [7:0] POSICAO;
  logic [7:0] GARRAFAS_SAIDAS;
  logic       ERRO_DERRAME;
  logic       ERRO_VEDACAO;

  modport master (
    output TICK, LED_MOTOR,
    output VALVULA_ENCHIMENTO,
    output ATUADOR_VEDACAO,
    input  SENSOR_POS_ENCHIMENTO,
    input  SENSOR_POS_CQ,
    input  SENSOR_POS_LACRE,
    input  SENSOR_GARRAFA_CHEIA,
    input  GARRAFA_PRESENTE,
    input  NIVEL, POSICAO,
    input  GARRAFAS_SAIDAS,
    input  ERRO_DERRAME, ERRO_VEDACAO
  );

  modport slave (
    input  TICK, LED_MOTOR,
    input  VALVULA_ENCHIMENTO,
    input  ATUADOR_VEDACAO,
    output SENSOR_POS_ENCHIMENTO,
    output SENSOR_POS_CQ,
    output SENSOR_POS_LACRE,
    output SENSOR_GARRAFA_CHEIA,
    output GARRAFA_PRESENTE,
    output NIVEL, POSICAO,
    output GARRAFAS_SAIDAS,
    output ERRO_DERRAME, ERRO_VEDACAO
  );
endinterface

// File: rtl/simulador_planta_esteira.sv
// Conveyor plant emulator: one bottle moving past filling,
// CQ and sealing stations, with spill / illegal-seal flags.
module simulador_planta_esteira #(
  parameter int D_ENCHIMENTO   = 8,
  parameter int D_CQ           = 16,
  parameter int D_LACRE        = 24,
  parameter int D_SAIDA        = 32,
  parameter int NIVEL_CHEIO    = 6,
  parameter int ATRASO_RECARGA = 4
) (
  input logic CLK,
  input logic RESET,
  simulador_planta_esteira_if.slave io
);
  localparam logic [0:0] CARREGANDO  = 1'b0;
  localparam logic [0:0] COM_GARRAFA = 1'b1;

  localparam logic [7:0] RECARGA_INI = 8'(ATRASO_RECARGA - 1);
  localparam logic [7:0] P_ENC   = 8'(D_ENCHIMENTO);
  localparam logic [7:0] P_CQ    = 8'(D_CQ);
  localparam logic [7:0] P_LACRE = 8'(D_LACRE);
  localparam logic [7:0] P_ULT   = 8'(D_SAIDA - 1);
  localparam logic [7:0] P_CHEIO = 8'(NIVEL_CHEIO);

  logic [0:0] state_q, state_d;
  logic [7:0] recarga_q, recarga_d;
  logic [7:0] posicao_q, posicao_d;
  logic [7:0] nivel_q, nivel_d;
  logic [7:0] saidas_q, saidas_d;
  logic       selada_q, selada_d;
  logic       derrame_q, derrame_d;
  logic       vedacao_q, vedacao_d;
  logic       ved_prev_q, ved_prev_d;
  logic       sen_enc_q, sen_enc_d;
  logic       sen_cq_q, sen_cq_d;
  logic       sen_lacre_q, sen_lacre_d;
  logic       cheia_q, cheia_d;
  logic       presente_q, presente_d;

  logic com, parado_enc, borda;
  logic com_d;

  always_comb begin
    state_d    = state_q;
    recarga_d  = recarga_q;
    posicao_d  = posicao_q;
    nivel_d    = nivel_q;
    saidas_d   = saidas_q;
    selada_d   = selada_q;
    derrame_d  = derrame_q;
    vedacao_d  = vedacao_q;
    ved_prev_d = io.ATUADOR_VEDACAO;

    com        = state_q == COM_GARRAFA;
    parado_enc = com && posicao_q == P_ENC
              && !io.LED_MOTOR;
    borda      = io.ATUADOR_VEDACAO && !ved_prev_q;

    // Seal edges are judged every CLK, not only on TICK.
    if (borda) begin
      if (parado_enc && cheia_q && !selada_q)
        selada_d = 1'b1;
      else
        vedacao_d = 1'b1;
    end

    if (io.TICK) begin
      if (io.VALVULA_ENCHIMENTO) begin
        if (parado_enc) begin
          if (nivel_q != 8'hFF)
            nivel_d = nivel_q + 8'd1;
        end else begin
          derrame_d = 1'b1;
        end
      end

      unique case (1'b1)
        !com: begin
          if (recarga_q == 8'd0) begin
            state_d   = COM_GARRAFA;
            posicao_d = 8'd0;
            nivel_d   = 8'd0;
            selada_d  = 1'b0;
          end else begin
            recarga_d = recarga_q - 8'd1;
          end
        end
        com && io.LED_MOTOR: begin
          if (posicao_q == P_ULT) begin
            state_d   = CARREGANDO;
            recarga_d = RECARGA_INI;
            posicao_d = 8'd0;
            nivel_d   = 8'd0;
            saidas_d  = saidas_q + 8'd1;
          end else begin
            posicao_d = posicao_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    // Sensors are registered copies of the next state.
    com_d       = state_d == COM_GARRAFA;
    presente_d  = com_d;
    sen_enc_d   = com_d && posicao_d == P_ENC;
    sen_cq_d    = com_d && posicao_d == P_CQ;
    sen_lacre_d = com_d && posicao_d == P_LACRE;
    cheia_d     = com_d && nivel_d >= P_CHEIO;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= CARREGANDO;
      recarga_q   <= RECARGA_INI;
      posicao_q   <= 8'd0;
      nivel_q     <= 8'd0;
      saidas_q    <= 8'd0;
      selada_q    <= 1'b0;
      derrame_q   <= 1'b0;
      vedacao_q   <= 1'b0;
      ved_prev_q  <= 1'b0;
      sen_enc_q   <= 1'b0;
      sen_cq_q    <= 1'b0;
      sen_lacre_q <= 1'b0;
      cheia_q     <= 1'b0;
      presente_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      recarga_q   <= recarga_d;
      posicao_q   <= posicao_d;
      nivel_q     <= nivel_d;
      saidas_q    <= saidas_d;
      selada_q    <= selada_d;
      derrame_q   <= derrame_d;
      vedacao_q   <= vedacao_d;
      ved_prev_q  <= ved_prev_d;
      sen_enc_q   <= sen_enc_d;
      sen_cq_q    <= sen_cq_d;
      sen_lacre_q <= sen_lacre_d;
      cheia_q     <= cheia_d;
      presente_q  <= presente_d;
    end
  end

  assign io.SENSOR_POS_ENCHIMENTO = sen_enc_q;
  assign io.SENSOR_POS_CQ         = sen_cq_q;
  assign io.SENSOR_POS_LACRE      = sen_lacre_q;
  assign io.SENSOR_GARRAFA_CHEIA  = cheia_q;
  assign io.GARRAFA_PRESENTE      = presente_q;
  assign io.NIVEL                 = nivel_q;
  assign io.POSICAO               = posicao_q;
  assign io.GARRAFAS_SAIDAS       = saidas_q;
  assign io.ERRO_DERRAME          = derrame_q;
  assign io.ERRO_VEDACAO          = vedacao_q;
endmodule

// File: tb/tb_simulador_planta_esteira.sv
// Bench for the conveyor plant: vector table, corner
// sequences and random stimulus against a bottle model.
module tb_simulador_planta_esteira;
  localparam int D_ENC = 8;
  localparam int D_CQ  = 16;
  localparam int D_LAC = 24;
  localparam int D_SAI = 32;
  localparam int CHEIO = 6;
  localparam int ATR   = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  simulador_planta_esteira_if bus ();

  simulador_planta_esteira #(
    .D_ENCHIMENTO  (D_ENC),
    .D_CQ          (D_CQ),
    .D_LACRE       (D_LAC),
    .D_SAIDA       (D_SAI),
    .NIVEL_CHEIO   (CHEIO),
    .ATRASO_RECARGA(ATR)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bottle model: one bottle or a reload wait.
  bit m_pres;
  int m_wait;
  int m_pos;
  int m_lvl;
  int m_exits;
  bit m_sealed;
  bit m_spill;
  bit m_sealerr;
  bit m_prev;

  function automatic void model_reset();
    m_pres    = 0;
    m_wait    = ATR;
    m_pos     = 0;
    m_lvl     = 0;
    m_exits   = 0;
    m_sealed  = 0;
    m_spill   = 0;
    m_sealerr = 0;
    m_prev    = 0;
  endfunction

  function automatic void model_clk(
    bit t, bit m, bit v, bit s
  );
    bit at_fill;
    at_fill = m_pres && m_pos == D_ENC && !m;
    if (s && !m_prev) begin
      if (at_fill && m_lvl >= CHEIO && !m_sealed)
        m_sealed = 1;
      else
        m_sealerr = 1;
    end
    m_prev = s;
    if (!t) return;
    if (v) begin
      if (at_fill) m_lvl = (m_lvl < 255) ? m_lvl + 1 : 255;
      else m_spill = 1;
    end
    if (!m_pres) begin
      m_wait--;
      if (m_wait == 0) begin
        m_pres = 1; m_pos = 0;
        m_lvl = 0;  m_sealed = 0;
      end
    end else if (m) begin
      m_pos++;
      if (m_pos == D_SAI) begin
        m_pres  = 0;
        m_wait  = ATR;
        m_exits = (m_exits + 1) % 256;
      end
    end
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit se, sq, sl, full;
    se   = m_pres && m_pos == D_ENC;
    sq   = m_pres && m_pos == D_CQ;
    sl   = m_pres && m_pos == D_LAC;
    full = m_pres && m_lvl >= CHEIO;
    chk({tag, ".pres"}, 32'(bus.GARRAFA_PRESENTE), 32'(m_pres));
    chk({tag, ".s_enc"}, 32'(bus.SENSOR_POS_ENCHIMENTO), 32'(se));
    chk({tag, ".s_cq"}, 32'(bus.SENSOR_POS_CQ), 32'(sq));
    chk({tag, ".s_lac"}, 32'(bus.SENSOR_POS_LACRE), 32'(sl));
    chk({tag, ".full"}, 32'(bus.SENSOR_GARRAFA_CHEIA), 32'(full));
    chk({tag, ".exits"}, 32'(bus.GARRAFAS_SAIDAS), 32'(m_exits));
    chk({tag, ".spill"}, 32'(bus.ERRO_DERRAME), 32'(m_spill));
    chk({tag, ".sealerr"}, 32'(bus.ERRO_VEDACAO), 32'(m_sealerr));
    if (m_pres) begin
      chk({tag, ".pos"}, 32'(bus.POSICAO), 32'(m_pos));
      chk({tag, ".lvl"}, 32'(bus.NIVEL), 32'(m_lvl));
    end
  endtask

  // One CLK; inputs driven 1 time unit after the edge.
  task automatic cyc(input bit t, m, v, s);
    bus.TICK               = t;
    bus.LED_MOTOR          = m;
    bus.VALVULA_ENCHIMENTO = v;
    bus.ATUADOR_VEDACAO    = s;
    @(posedge clk);
    model_clk(t, m, v, s);
    #1;
  endtask

  // One TICK followed by three idle CLKs.
  task automatic do_tick(input bit m, v, s);
    cyc(1, m, v, s);
    repeat (3) cyc(0, m, v, s);
  endtask

  task automatic do_reset();
    bus.TICK               = 0;
    bus.LED_MOTOR          = 0;
    bus.VALVULA_ENCHIMENTO = 0;
    bus.ATUADOR_VEDACAO    = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".pres"}, 32'(bus.GARRAFA_PRESENTE), 0);
    chk({tag, ".s_enc"}, 32'(bus.SENSOR_POS_ENCHIMENTO), 0);
    chk({tag, ".s_cq"}, 32'(bus.SENSOR_POS_CQ), 0);
    chk({tag, ".s_lac"}, 32'(bus.SENSOR_POS_LACRE), 0);
    chk({tag, ".full"}, 32'(bus.SENSOR_GARRAFA_CHEIA), 0);
    chk({tag, ".pos"}, 32'(bus.POSICAO), 0);
    chk({tag, ".lvl"}, 32'(bus.NIVEL), 0);
    chk({tag, ".exits"}, 32'(bus.GARRAFAS_SAIDAS), 0);
    chk({tag, ".spill"}, 32'(bus.ERRO_DERRAME), 0);
    chk({tag, ".sealerr"}, 32'(bus.ERRO_VEDACAO), 0);
  endtask

  typedef struct {
    bit m; bit v; bit s; int n;
    bit pres; int pos; int lvl;
    bit se; bit sq; bit sl; bit full;
    bit ed; bit ev; int ex;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    bit m, bit v, bit s, int n,
    bit pres, int pos, int lvl,
    bit se, bit sq, bit sl, bit full,
    bit ed, bit ev, int ex
  );
    vec_t r;
    r.m = m; r.v = v; r.s = s; r.n = n;
    r.pres = pres; r.pos = pos; r.lvl = lvl;
    r.se = se; r.sq = sq; r.sl = sl; r.full = full;
    r.ed = ed; r.ev = ev; r.ex = ex;
    tbl.push_back(r);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 0;
    bus.TICK               = 0;
    bus.LED_MOTOR          = 0;
    bus.VALVULA_ENCHIMENTO = 0;
    bus.ATUADOR_VEDACAO    = 0;
    model_reset();

    //  m v s  n  pres pos lvl se sq sl full ed ev ex
    add(0,0,0, 3, 0,  0, 0, 0,0,0,0, 0,0,0);
    add(0,0,0, 1, 1,  0, 0, 0,0,0,0, 0,0,0);
    add(1,0,0, 7, 1,  7, 0, 0,0,0,0, 0,0,0);
    add(1,0,0, 1, 1,  8, 0, 1,0,0,0, 0,0,0);
    add(0,0,0,10, 1,  8, 0, 1,0,0,0, 0,0,0);
    add(0,1,0, 5, 1,  8, 5, 1,0,0,0, 0,0,0);
    add(0,1,0, 1, 1,  8, 6, 1,0,0,1, 0,0,0);
    add(0,0,1, 1, 1,  8, 6, 1,0,0,1, 0,0,0);
    add(0,0,0, 1, 1,  8, 6, 1,0,0,1, 0,0,0);
    add(0,0,1, 1, 1,  8, 6, 1,0,0,1, 0,1,0);
    add(0,0,0, 1, 1,  8, 6, 1,0,0,1, 0,1,0);
    add(1,0,0, 8, 1, 16, 6, 0,1,0,1, 0,1,0);
    add(1,0,0, 8, 1, 24, 6, 0,0,1,1, 0,1,0);
    add(1,0,0, 7, 1, 31, 6, 0,0,0,1, 0,1,0);
    add(1,0,0, 1, 0,  0, 0, 0,0,0,0, 0,1,1);
    add(0,1,0, 1, 0,  0, 0, 0,0,0,0, 1,1,1);
    add(0,0,0, 2, 0,  0, 0, 0,0,0,0, 1,1,1);
    add(0,0,0, 1, 1,  0, 0, 0,0,0,0, 1,1,1);

    // Reset state while held in reset
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    do_reset();
    check_zero("rst_rel");

    foreach (tbl[i]) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      repeat (tbl[i].n)
        do_tick(tbl[i].m, tbl[i].v, tbl[i].s);
      chk({tg, ".pres"}, 32'(bus.GARRAFA_PRESENTE), 32'(tbl[i].pres));
      chk({tg, ".s_enc"}, 32'(bus.SENSOR_POS_ENCHIMENTO), 32'(tbl[i].se));
      chk({tg, ".s_cq"}, 32'(bus.SENSOR_POS_CQ), 32'(tbl[i].sq));
      chk({tg, ".s_lac"}, 32'(bus.SENSOR_POS_LACRE), 32'(tbl[i].sl));
      chk({tg, ".full"}, 32'(bus.SENSOR_GARRAFA_CHEIA), 32'(tbl[i].full));
      chk({tg, ".spill"}, 32'(bus.ERRO_DERRAME), 32'(tbl[i].ed));
      chk({tg, ".sealerr"}, 32'(bus.ERRO_VEDACAO), 32'(tbl[i].ev));
      chk({tg, ".exits"}, 32'(bus.GARRAFAS_SAIDAS), 32'(tbl[i].ex));
      if (tbl[i].pres) begin
        chk({tg, ".pos"}, 32'(bus.POSICAO), 32'(tbl[i].pos));
        chk({tg, ".lvl"}, 32'(bus.NIVEL), 32'(tbl[i].lvl));
      end
      check_model({tg, ".mdl"});
    end

    // Valve open on the TICK that moves the bottle off the filler
    do_reset();
    repeat (4) do_tick(0, 0, 0);
    repeat (8) do_tick(1, 0, 0);
    repeat (2) do_tick(0, 1, 0);
    chk("mv.lvl_pre", 32'(bus.NIVEL), 2);
    chk("mv.spill_pre", 32'(bus.ERRO_DERRAME), 0);
    do_tick(1, 1, 0);
    chk("mv.pos", 32'(bus.POSICAO), 9);
    chk("mv.lvl", 32'(bus.NIVEL), 2);
    chk("mv.spill", 32'(bus.ERRO_DERRAME), 1);
    chk("mv.s_enc", 32'(bus.SENSOR_POS_ENCHIMENTO), 0);
    check_model("mv.mdl");

    // Valve in the reload wait only
    do_reset();
    do_tick(0, 1, 0);
    chk("ld.spill", 32'(bus.ERRO_DERRAME), 1);
    chk("ld.pres", 32'(bus.GARRAFA_PRESENTE), 0);

    // Async reset mid-transit, no clock edge
    do_reset();
    repeat (4) do_tick(0, 0, 0);
    repeat (5) do_tick(1, 0, 0);
    do_tick(1, 1, 1);
    repeat (14) do_tick(1, 0, 0);
    chk("ar.pos", 32'(bus.POSICAO), 20);
    chk("ar.spill", 32'(bus.ERRO_DERRAME), 1);
    chk("ar.sealerr", 32'(bus.ERRO_VEDACAO), 1);
    check_model("ar.mdl");
    #2;
    rst_n = 0;
    #1;
    check_zero("ar.async");
    @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) do_tick(1, 0, 0);
    chk("ar.wait3", 32'(bus.GARRAFA_PRESENTE), 0);
    do_tick(1, 0, 0);
    chk("ar.load", 32'(bus.GARRAFA_PRESENTE), 1);
    chk("ar.pos0", 32'(bus.POSICAO), 0);

    // Exit counter wrap with TICK on every CLK
    do_reset();
    repeat (255 * (ATR + D_SAI)) cyc(1, 1, 0, 0);
    chk("wr.255", 32'(bus.GARRAFAS_SAIDAS), 255);
    chk("wr.pres", 32'(bus.GARRAFA_PRESENTE), 0);
    repeat (ATR + D_SAI) cyc(1, 1, 0, 0);
    chk("wr.0", 32'(bus.GARRAFAS_SAIDAS), 0);
    check_model("wr.mdl");

    // Random closed-loop-free stimulus vs model
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int k = 0; k < 500; k++) begin
        bit t, m, v, s;
        t = 1'($urandom_range(0, 1));
        m = $urandom_range(0, 9) < 7;
        v = $urandom_range(0, 19) == 0;
        s = $urandom_range(0, 19) == 0;
        if (m_pres && m_pos == D_ENC
            && $urandom_range(0, 3) != 0) begin
          m = 0;
          v = $urandom_range(0, 1) == 1;
        end
        cyc(t, m, v, s);
        check_model($sformatf("rnd%0d", seg));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simulador_planta_esteira.md
# simulador_planta_esteira

Plant emulator for the wine-bottling conveyor: the other end of the controller's actuator/sensor interface. It consumes the motor, filling-valve and sealing-actuator outputs and drives the conveyor position sensors and the bottle-full sensor. Each bottle is modelled as a position counter moving along the belt past the filling, quality-control (CQ) and sealing stations. It replaces physical switches in closed-loop board demos and in controller regression benches.

## Interface

**Parameters**

- `D_ENCHIMENTO`, default 8: filling-station position.
- `D_CQ`, default 16: CQ-station position.
- `D_LACRE`, default 24: sealing-station position.
- `D_SAIDA`, default 32: belt exit position. Legal only if `0 < D_ENCHIMENTO < D_CQ < D_LACRE < D_SAIDA ≤ 255`.
- `NIVEL_CHEIO`, default 6: fill level (in ticks) at which the bottle counts as full. Range 1..255.
- `ATRASO_RECARGA`, default 4: ticks between a bottle leaving and the next bottle appearing at position 0.

**Ports**

- `CLK` input, 1: the single clock.
- `RESET` input, 1: asynchronous, active-low reset.
- `TICK` input, 1: one-CLK-wide enable; all plant time advances only on CLK edges where TICK=1.
- `LED_MOTOR` input, 1: belt motor on.
- `VALVULA_ENCHIMENTO` input, 1: filling valve open.
- `ATUADOR_VEDACAO` input, 1: sealing actuator; edge-detected.
- `SENSOR_POS_ENCHIMENTO` output, 1: bottle at filling station.
- `SENSOR_POS_CQ` output, 1: bottle at CQ station.
- `SENSOR_POS_LACRE` output, 1: bottle at sealing station.
- `SENSOR_GARRAFA_CHEIA` output, 1: current bottle full.
- `GARRAFA_PRESENTE` output, 1: a bottle is on the belt.
- `NIVEL` output, 8: fill level of the current bottle.
- `POSICAO` output, 8: position of the current bottle.
- `GARRAFAS_SAIDAS` output, 8: count of bottles that have exited.
- `ERRO_DERRAME` output, 1: sticky spill error.
- `ERRO_VEDACAO` output, 1: sticky illegal-seal error.

## Operation

**States**

- **CARREGANDO**: no bottle on the belt.
  - Reload counter decrements on each TICK.
  - On the TICK where the counter is 0: go to COM_GARRAFA with `POSICAO`=0, `NIVEL`=0, selada=0.
- **COM_GARRAFA**: bottle on the belt.
  - On each TICK with `LED_MOTOR`=1: `POSICAO` += 1.
  - On the TICK where `POSICAO` would become `D_SAIDA`: go to CARREGANDO, reload counter = `ATRASO_RECARGA`−1, `GARRAFAS_SAIDAS` += 1 (wraps 255→0).
  - `LED_MOTOR`=1 in CARREGANDO has no effect.

**Sensors**

- Each station sensor is 1 iff the state is COM_GARRAFA and `POSICAO` equals that station's parameter.
- A sensor stays high for as long as the belt is stopped at the station.
- All sensors are 0 in CARREGANDO.

**Filling**

- On a TICK with `VALVULA_ENCHIMENTO`=1, `LED_MOTOR`=0, COM_GARRAFA and `POSICAO`=`D_ENCHIMENTO`: `NIVEL` += 1, saturating at 255.
- `SENSOR_GARRAFA_CHEIA` = COM_GARRAFA and (`NIVEL` ≥ `NIVEL_CHEIO`).
- On a TICK with `VALVULA_ENCHIMENTO`=1 under any other condition: `ERRO_DERRAME` is set to 1 and `NIVEL` is unchanged.

**Sealing**

- A rising edge of `ATUADOR_VEDACAO` is detected on CLK, independent of TICK, using a registered previous value.
- The edge is legal only if all of the following hold: COM_GARRAFA, `POSICAO`=`D_ENCHIMENTO`, `LED_MOTOR`=0, full, and selada=0.
- Legal edge: selada is set to 1.
- Any other edge: `ERRO_VEDACAO` is set to 1.

**Error flags**

- Both error flags are sticky; only `RESET` clears them.

**Simultaneous events**

- A spill and an illegal seal in the same cycle set both flags.
- A TICK that both moves the bottle off `D_ENCHIMENTO` and sees the valve open: the move happens and `ERRO_DERRAME` is set, because the motor is on.
- A bottle exiting on the same TICK as valve=1 sets `ERRO_DERRAME`.

## Timing

**Reset (asynchronous, `RESET`=0)**

- State = CARREGANDO, reload counter = `ATRASO_RECARGA`−1.
- All outputs 0: `POSICAO`, `NIVEL`, `GARRAFAS_SAIDAS`, all sensors, `GARRAFA_PRESENTE`, both error flags.
- Edge-detect register = 0.
- Reset asserted mid-transit discards the bottle.

**Output timing**

- All outputs are registered.
- A change caused by a TICK edge is visible from the next CLK edge onward; there is no combinational path from inputs to outputs.
- First bottle appears `ATRASO_RECARGA` TICKs after reset release.
- A bottle needs `D_ENCHIMENTO` motor-on TICKs from load to the filling sensor, and `D_SAIDA` motor-on TICKs from load to exit.
- A controller that clears `LED_MOTOR` in the cycle after a sensor rises, and before the next TICK, stops exactly at the station.

## Test plan

1. **Load delay.** Release reset, TICK every 4 CLKs, motor off → `GARRAFA_PRESENTE`=1 after 4 TICKs; all sensors 0; `POSICAO`=0.
2. **Reach filling station.** Motor on → `SENSOR_POS_ENCHIMENTO`=1 after 8 more TICKs. Drop the motor → sensor holds and `POSICAO` stays 8 over 10 further TICKs.
3. **Fill and seal.** At the filling station, valve on for 6 TICKs → `NIVEL`=6 and `SENSOR_GARRAFA_CHEIA`=1. Then pulse `ATUADOR_VEDACAO` once → `ERRO_VEDACAO` stays 0. A second pulse → `ERRO_VEDACAO`=1.
4. **Spill errors.**
   - Valve on during one motor-on TICK → `ERRO_DERRAME`=1 and `NIVEL` unchanged; the flag survives the next bottle.
   - Valve on in CARREGANDO → `ERRO_DERRAME`=1.
5. **Full pass and counter wrap.**
   - Drive continuously → CQ sensor at `POSICAO` 16 and lacre sensor at 24. At the 32nd motor TICK: `GARRAFA_PRESENTE`=0 and `GARRAFAS_SAIDAS`=1.
   - After 256 bottles → `GARRAFAS_SAIDAS`=0.
6. **Async reset mid-transit.** Assert `RESET` mid-transit at `POSICAO`=20 with both errors set, no clock edge → all outputs 0 immediately; the load delay restarts.
